// File: rtl/axi_clip_arb.sv
// Packet-granular round-robin arbiter feeding one saturating WIDTH_IN->WIDTH_OUT clip stage.
// Output beats carry the source index in o_tdest; per-port saturating clip counters for readback.
module axi_clip_arb #(
    parameter int unsigned WIDTH_IN  = 24,
    parameter int unsigned WIDTH_OUT = 16,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*WIDTH_IN-1:0]  i_tdata,
    input  logic [NUM_PORTS-1:0]           i_tlast,
    input  logic [NUM_PORTS-1:0]           i_tvalid,
    output logic [NUM_PORTS-1:0]           i_tready,
    output logic [WIDTH_OUT-1:0]           o_tdata,
    output logic                           o_tlast,
    output logic [1:0]                     o_tdest,
    output logic                           o_tvalid,
    input  logic                           o_tready,
    input  logic                           clear_cnt,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] clip_cnt
);
    localparam int unsigned PW    = 2;
    localparam int unsigned TOP_W = WIDTH_IN - WIDTH_OUT + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]                  grant_q, grant_d;
    logic [WIDTH_OUT-1:0]           o_tdata_q, o_tdata_d;
    logic                           o_tlast_q, o_tlast_d;
    logic [PW-1:0]                  o_tdest_q, o_tdest_d;
    logic                           o_tvalid_q, o_tvalid_d;
    logic [NUM_PORTS*CNT_WIDTH-1:0] clip_cnt_q, clip_cnt_d;

    logic [WIDTH_IN-1:0]  sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic [TOP_W-1:0]     top;
    logic                 overflow;
    logic [WIDTH_OUT-1:0] clipped;
    logic                 out_ready;
    logic                 accept;
    logic                 found_hi, found_lo;
    logic [PW-1:0]        pick_hi, pick_lo;
    logic [PW-1:0]        next_ptr;

    // Mux the granted port's beat
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == PW'(p)) begin
                sel_data  = i_tdata[p*WIDTH_IN +: WIDTH_IN];
                sel_valid = i_tvalid[p];
                sel_last  = i_tlast[p];
            end
        end
    end

    // Saturating clip: overflow whenever the dropped bits plus new sign bit disagree
    assign top      = sel_data[WIDTH_IN-1:WIDTH_OUT-1];
    assign overflow = ~((&top) | ~(|top));
    assign clipped  = overflow ? (sel_data[WIDTH_IN-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                                       : {1'b0, {(WIDTH_OUT-1){1'b1}}})
                               : sel_data[WIDTH_OUT-1:0];

    assign out_ready = ~o_tvalid_q | o_tready;
    assign accept    = (state_q == BUSY) & sel_valid & out_ready;
    assign next_ptr  = (grant_q == PW'(NUM_PORTS-1)) ? '0 : grant_q + PW'(1);

    always_comb begin
        i_tready = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if ((state_q == BUSY) && (grant_q == PW'(p))) i_tready[p] = out_ready;
        end
    end

    // Round-robin search: first valid at or above rr_ptr, else first valid below it
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (i_tvalid[p] && (PW'(p) >= rr_ptr_q) && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = PW'(p);
            end
            if (i_tvalid[p] && (PW'(p) < rr_ptr_q) && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = PW'(p);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_tdest_d  = o_tdest_q;
        o_tvalid_d = o_tvalid_q;
        case (state_q)
            IDLE: begin
                if (found_hi || found_lo) begin
                    grant_d = found_hi ? pick_hi : pick_lo;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            o_tdata_d  = clipped;
            o_tlast_d  = sel_last;
            o_tdest_d  = grant_q;
            o_tvalid_d = 1'b1;
        end else if (o_tready) begin
            o_tvalid_d = 1'b0;
        end
    end

    // Per-port clip counters; clear takes priority over a same-cycle increment
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (clear_cnt) begin
                clip_cnt_d[p*CNT_WIDTH +: CNT_WIDTH] = '0;
            end else if (accept && overflow && (grant_q == PW'(p))
                         && !(&clip_cnt_q[p*CNT_WIDTH +: CNT_WIDTH])) begin
                clip_cnt_d[p*CNT_WIDTH +: CNT_WIDTH] =
                    clip_cnt_q[p*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tdest_q  <= '0;
            o_tvalid_q <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_tdest_q  <= o_tdest_d;
            o_tvalid_q <= o_tvalid_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tdest  = o_tdest_q;
    assign o_tvalid = o_tvalid_q;
    assign clip_cnt = clip_cnt_q;

endmodule
